// File: rtl/pika_pipe_ctrl.sv
// Pipeline sequencer for PikaRISC: PC, per-stage valids, stall/bubble/flush and EX forwarding select.
// Optional PIKA_PERF_CNT_EN adds retire_cnt/stall_cnt performance counters.
module pika_pipe_ctrl #(
  parameter int               XLEN         = 32,
  parameter int               RNUM_W       = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               PC_STEP      = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [XLEN-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic [RNUM_W-1:0] id_rs_num,
  input  logic [RNUM_W-1:0] id_rt_num,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [RNUM_W-1:0] ex_rd_num,
  input  logic              ex_rd_we,
  input  logic              ex_is_ld,
  input  logic              ex_taken,
  input  logic [XLEN-1:0]   ex_target,
  input  logic [RNUM_W-1:0] mem_rd_num,
  input  logic              mem_rd_we,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic [RNUM_W-1:0] wb_rd_num,
  input  logic              wb_rd_we,
  output logic [4:0]        stage_valid,
  output logic [4:0]        stage_en,
  output logic              flush,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel
`ifdef PIKA_PERF_CNT_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int S_IF  = 0;
  localparam int S_ID  = 1;
  localparam int S_EX  = 2;
  localparam int S_MEM = 3;
  localparam int S_WB  = 4;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      vld_q, vld_d;
  logic            mem_ld_q, mem_ld_d;
  logic [4:0]      en;
  logic            dwait, ex_br, lu_hit, lu, iwait;
  logic            mem_fwd_ok, wb_fwd_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_VECTOR;
      vld_q    <= '0;
      mem_ld_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      mem_ld_q <= mem_ld_d;
    end
  end

  // Hazard detection, highest priority first; lower causes are masked by higher ones.
  always_comb begin
    dwait  = vld_q[S_MEM] & dmem_req & ~dmem_ready;
    ex_br  = vld_q[S_EX] & ex_taken & ~dwait;
    lu_hit = (id_uses_rs & (ex_rd_num == id_rs_num)) |
             (id_uses_rt & (ex_rd_num == id_rt_num));
    lu     = vld_q[S_EX] & vld_q[S_ID] & ex_is_ld & ex_rd_we & lu_hit & ~dwait & ~ex_br;
    iwait  = ~imem_ready & ~dwait & ~ex_br & ~lu;
  end

  always_comb begin
    pc_d  = pc_q;
    vld_d = vld_q;
    en    = 5'b11111;
    if (dwait) begin
      en           = 5'b10000;
      vld_d[S_WB]  = 1'b0;
    end else if (ex_br) begin
      // Wrong-path instructions in IF and ID are dropped, and this cycle's fetch too.
      pc_d  = ex_target;
      vld_d = {vld_q[S_MEM], vld_q[S_EX], 3'b000};
    end else if (lu) begin
      en    = 5'b11100;
      vld_d = {vld_q[S_MEM], vld_q[S_EX], 1'b0, vld_q[S_ID], vld_q[S_IF]};
    end else if (iwait) begin
      en    = 5'b11110;
      vld_d = {vld_q[S_MEM], vld_q[S_EX], vld_q[S_ID], 1'b0, vld_q[S_IF]};
    end else begin
      pc_d  = pc_q + STEP;
      vld_d = {vld_q[3:0], 1'b1};
    end
    mem_ld_d = en[S_MEM] ? (ex_is_ld & vld_d[S_MEM]) : mem_ld_q;
  end

  // A load in MEM has no result until its data access completes.
  always_comb begin
    mem_fwd_ok = vld_q[S_MEM] & mem_rd_we & (~mem_ld_q | dmem_ready);
    wb_fwd_ok  = vld_q[S_WB] & wb_rd_we;
    fwd_rs_sel = 2'd0;
    fwd_rt_sel = 2'd0;
    if (id_uses_rs) begin
      if (mem_fwd_ok && mem_rd_num == id_rs_num)     fwd_rs_sel = 2'd1;
      else if (wb_fwd_ok && wb_rd_num == id_rs_num)  fwd_rs_sel = 2'd2;
    end
    if (id_uses_rt) begin
      if (mem_fwd_ok && mem_rd_num == id_rt_num)     fwd_rt_sel = 2'd1;
      else if (wb_fwd_ok && wb_rd_num == id_rt_num)  fwd_rt_sel = 2'd2;
    end
  end

  always_comb begin
    imem_addr   = pc_q;
    imem_req    = reset;
    stage_valid = vld_q;
    stage_en    = reset ? en : 5'b00000;
    flush       = reset & ex_br;
  end

`ifdef PIKA_PERF_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q + {31'd0, vld_q[S_WB]};
    stall_cnt_d  = stall_cnt_q + {31'd0, (dwait | lu | iwait)};
    retire_cnt   = retire_cnt_q;
    stall_cnt    = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_pika_pipe_ctrl.sv
// Directed bench for pika_pipe_ctrl: sequencing, load-use, flush, dmem freeze, forwarding, reset.
module tb_pika_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [3:0]  id_rs_num, id_rt_num, ex_rd_num, mem_rd_num, wb_rd_num;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_rd_we, ex_is_ld, ex_taken;
  logic [31:0] ex_target;
  logic        mem_rd_we, dmem_req, dmem_ready, wb_rd_we;
  logic [4:0]  stage_valid, stage_en;
  logic        flush;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
`ifdef PIKA_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pika_pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd_num(ex_rd_num), .ex_rd_we(ex_rd_we), .ex_is_ld(ex_is_ld),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .mem_rd_num(mem_rd_num), .mem_rd_we(mem_rd_we),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_rd_num(wb_rd_num), .wb_rd_we(wb_rd_we),
    .stage_valid(stage_valid), .stage_en(stage_en), .flush(flush),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
`ifdef PIKA_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    imem_ready = 1'b1; dmem_ready = 1'b1; dmem_req = 1'b0;
    id_rs_num = '0; id_rt_num = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_rd_num = '0; ex_rd_we = 1'b0; ex_is_ld = 1'b0; ex_taken = 1'b0; ex_target = '0;
    mem_rd_num = '0; mem_rd_we = 1'b0; wb_rd_num = '0; wb_rd_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    quiet();
    #12;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_vld", {27'd0, stage_valid}, 32'h0);
    chk("rst_en", {27'd0, stage_en}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'h0);

    // sequential flow
    reset = 1'b1;
    #1;
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_req", {31'd0, imem_req}, 32'h1);
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk("seq_addr", imem_addr, 32'(4 * n));
      chk("seq_vld", {27'd0, stage_valid}, (32'd1 << n) - 32'd1);
    end

    // load-use on r3
    ex_is_ld = 1'b1; ex_rd_we = 1'b1; ex_rd_num = 4'd3;
    id_rs_num = 4'd3; id_uses_rs = 1'b1;
    #1;
    chk("lu_en", {27'd0, stage_en}, 32'h1c);
    tick();
    chk("lu_pc_held", imem_addr, 32'd20);
    chk("lu_vld", {27'd0, stage_valid}, 32'h1b);
    ex_is_ld = 1'b0; ex_rd_we = 1'b0;
    mem_rd_num = 4'd3; mem_rd_we = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("ld_notready_fwd", {30'd0, fwd_rs_sel}, 32'd0);
    chk("ld_notready_en", {27'd0, stage_en}, 32'h10);
    dmem_ready = 1'b1;
    #1;
    chk("ld_ready_fwd", {30'd0, fwd_rs_sel}, 32'd1);
    chk("ld_ready_en", {27'd0, stage_en}, 32'h1f);
    tick();
    chk("post_lu_pc", imem_addr, 32'd24);
    chk("post_lu_vld", {27'd0, stage_valid}, 32'h17);
    quiet();

    // taken branch
    ex_taken = 1'b1; ex_target = 32'h100;
    #1;
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_en", {27'd0, stage_en}, 32'h1f);
    tick();
    ex_taken = 1'b0;
    #1;
    chk("br_pc", imem_addr, 32'h100);
    chk("br_vld", {27'd0, stage_valid}, 32'h08);
    chk("br_flush_once", {31'd0, flush}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("refill_pc", imem_addr, 32'h110);
    chk("refill_vld", {27'd0, stage_valid}, 32'h0f);

    // dmem wait overriding a pending branch for 3 cycles
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_taken = 1'b1; ex_target = 32'h200;
    #1;
    chk("dw_flush0", {31'd0, flush}, 32'd0);
    chk("dw_en", {27'd0, stage_en}, 32'h10);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("dw_pc", imem_addr, 32'h110);
      chk("dw_vld", {27'd0, stage_valid}, 32'h0f);
      if (k < 3) chk("dw_flush", {31'd0, flush}, 32'd0);
    end
    dmem_ready = 1'b1;
    #1;
    chk("dw_end_flush", {31'd0, flush}, 32'd1);
    tick();
    chk("dw_br_pc", imem_addr, 32'h200);
    chk("dw_br_vld", {27'd0, stage_valid}, 32'h18);
    quiet();

    // forwarding priority on r5
    mem_rd_num = 4'd5; mem_rd_we = 1'b1; wb_rd_num = 4'd5; wb_rd_we = 1'b1;
    id_rt_num = 4'd5; id_uses_rt = 1'b1;
    #1;
    chk("fwd_mem_wins", {30'd0, fwd_rt_sel}, 32'd1);
    chk("fwd_rs_unused", {30'd0, fwd_rs_sel}, 32'd0);
    id_uses_rt = 1'b0;
    #1;
    chk("fwd_rt_unused", {30'd0, fwd_rt_sel}, 32'd0);
    id_uses_rt = 1'b1;
    tick();
    chk("fwd_vld", {27'd0, stage_valid}, 32'h11);
    chk("fwd_wb", {30'd0, fwd_rt_sel}, 32'd2);
    quiet();

    // imem wait
    imem_ready = 1'b0;
    #1;
    chk("iw_en", {27'd0, stage_en}, 32'h1e);
    tick();
    chk("iw_pc", imem_addr, 32'h204);
    chk("iw_vld", {27'd0, stage_valid}, 32'h01);
    imem_ready = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_vld", {27'd0, stage_valid}, 32'h0f);

    // reset during dmem freeze
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    chk("frz_pc", imem_addr, 32'h210);
    reset = 1'b0;
    #1;
    chk("mrst_vld", {27'd0, stage_valid}, 32'h0);
    chk("mrst_pc", imem_addr, 32'h0);
    chk("mrst_en", {27'd0, stage_en}, 32'h0);
    chk("mrst_req", {31'd0, imem_req}, 32'h0);
`ifdef PIKA_PERF_CNT_EN
    chk("mrst_retire", retire_cnt, 32'h0);
    chk("mrst_stall", stall_cnt, 32'h0);
`endif
    quiet();
    #2;
    reset = 1'b1;
    tick();
    chk("restart_pc", imem_addr, 32'h4);
    chk("restart_vld", {27'd0, stage_valid}, 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
